// File: rtl/regfile_pkg.sv
// Shared RV32I register-file constants: data width, index width and the x0 index.
package regfile_pkg;

   localparam int unsigned RF_XLEN          = 32;
   localparam int unsigned RF_REG_NUM       = 32;
   localparam int unsigned RF_REG_IDX_WIDTH = 5;
   localparam int unsigned REG_X0           = 0;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback/issue bundle between the ID stage and the register file.
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN          = RF_XLEN,
   parameter int unsigned REG_IDX_WIDTH = RF_REG_IDX_WIDTH
);

   logic [REG_IDX_WIDTH-1:0] rs1_idx_i;
   logic                     rs1_en_i;
   logic [REG_IDX_WIDTH-1:0] rs2_idx_i;
   logic                     rs2_en_i;
   logic [XLEN-1:0]          rs1_rdata_o;
   logic [XLEN-1:0]          rs2_rdata_o;
   logic                     wb_en_i;
   logic [REG_IDX_WIDTH-1:0] wb_idx_i;
   logic [XLEN-1:0]          wb_wdata_i;
   logic                     issue_valid_i;
   logic                     issue_load_i;
   logic [REG_IDX_WIDTH-1:0] issue_rd_idx_i;
   logic                     issue_rd_en_i;
   logic                     load_use_stall_o;

   modport master (
      output rs1_idx_i, rs1_en_i, rs2_idx_i, rs2_en_i,
      output wb_en_i, wb_idx_i, wb_wdata_i,
      output issue_valid_i, issue_load_i, issue_rd_idx_i, issue_rd_en_i,
      input  rs1_rdata_o, rs2_rdata_o, load_use_stall_o
   );

   modport slave (
      input  rs1_idx_i, rs1_en_i, rs2_idx_i, rs2_en_i,
      input  wb_en_i, wb_idx_i, wb_wdata_i,
      input  issue_valid_i, issue_load_i, issue_rd_idx_i, issue_rd_en_i,
      output rs1_rdata_o, rs2_rdata_o, load_use_stall_o
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Load-pending busy bits: set on load issue, cleared on writeback, with two lookup ports.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned REG_NUM       = RF_REG_NUM,
   parameter int unsigned REG_IDX_WIDTH = RF_REG_IDX_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     issue_valid_i,
   input  logic                     issue_load_i,
   input  logic                     issue_rd_en_i,
   input  logic [REG_IDX_WIDTH-1:0] issue_rd_idx_i,
   input  logic                     wb_en_i,
   input  logic [REG_IDX_WIDTH-1:0] wb_idx_i,
   input  logic [REG_IDX_WIDTH-1:0] rs1_idx_i,
   input  logic [REG_IDX_WIDTH-1:0] rs2_idx_i,
   output logic                     rs1_busy_o,
   output logic                     rs2_busy_o
);

   localparam logic [REG_IDX_WIDTH-1:0] X0_IDX = REG_IDX_WIDTH'(REG_X0);

   logic [REG_NUM-1:0] busy_q, busy_d;
   logic               set_en, clr_en;

   assign set_en = issue_valid_i & issue_load_i & issue_rd_en_i & (issue_rd_idx_i != X0_IDX);
   assign clr_en = wb_en_i & (wb_idx_i != X0_IDX);

   // Set is applied after clear: the newly issued load is younger than the writeback.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[wb_idx_i] = 1'b0;
      if (set_en) busy_d[issue_rd_idx_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign rs1_busy_o = busy_q[rs1_idx_i];
   assign rs2_busy_o = busy_q[rs2_idx_i];

endmodule

// File: rtl/regfile.sv
// RV32I integer register file: two write-through read ports, one writeback port,
// and the load-use stall derived from the load-pending scoreboard.
module regfile
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN          = RF_XLEN,
   parameter int unsigned REG_NUM       = RF_REG_NUM,
   parameter int unsigned REG_IDX_WIDTH = RF_REG_IDX_WIDTH
) (
   input  logic      clk,
   input  logic      rst_n,
   regfile_if.slave  bus
);

   localparam logic [REG_IDX_WIDTH-1:0] X0_IDX = REG_IDX_WIDTH'(REG_X0);

   logic [XLEN-1:0]          regs_q [1:REG_NUM-1];
   logic                     wb_we;
   logic [REG_IDX_WIDTH-1:0] rd_idx  [2];
   logic                     rd_en   [2];
   logic [XLEN-1:0]          rd_data [2];
   logic                     rd_fwd  [2];
   logic [1:0]               rd_busy;
   logic [1:0]               rd_stall;

   assign wb_we = bus.wb_en_i & (bus.wb_idx_i != X0_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < int'(REG_NUM); i++) regs_q[i] <= '0;
      end else if (wb_we) begin
         regs_q[bus.wb_idx_i] <= bus.wb_wdata_i;
      end
   end

   regfile_scoreboard #(
      .REG_NUM       (REG_NUM),
      .REG_IDX_WIDTH (REG_IDX_WIDTH)
   ) u_scoreboard (
      .clk            (clk),
      .rst_n          (rst_n),
      .issue_valid_i  (bus.issue_valid_i),
      .issue_load_i   (bus.issue_load_i),
      .issue_rd_en_i  (bus.issue_rd_en_i),
      .issue_rd_idx_i (bus.issue_rd_idx_i),
      .wb_en_i        (bus.wb_en_i),
      .wb_idx_i       (bus.wb_idx_i),
      .rs1_idx_i      (bus.rs1_idx_i),
      .rs2_idx_i      (bus.rs2_idx_i),
      .rs1_busy_o     (rd_busy[0]),
      .rs2_busy_o     (rd_busy[1])
   );

   assign rd_idx[0] = bus.rs1_idx_i;
   assign rd_idx[1] = bus.rs2_idx_i;
   assign rd_en[0]  = bus.rs1_en_i;
   assign rd_en[1]  = bus.rs2_en_i;

   // A writeback to the requested register both supplies the data and cancels the stall.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p]  = '0;
         rd_fwd[p]   = 1'b0;
         rd_stall[p] = 1'b0;
         if (rd_en[p] && (rd_idx[p] != X0_IDX)) begin
            rd_fwd[p]   = bus.wb_en_i && (bus.wb_idx_i == rd_idx[p]);
            rd_data[p]  = rd_fwd[p] ? bus.wb_wdata_i : regs_q[rd_idx[p]];
            rd_stall[p] = rd_busy[p] & ~rd_fwd[p];
         end
      end
   end

   assign bus.rs1_rdata_o      = rd_data[0];
   assign bus.rs2_rdata_o      = rd_data[1];
   assign bus.load_use_stall_o = |rd_stall;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: hand-written vector table, reset corner case,
// then constrained-random traffic checked against a small reference model.
module tb_regfile;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   regfile_if rf ();

   regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (rf)
   );

   typedef struct {
      logic        rs1_en;
      logic [4:0]  rs1_idx;
      logic        rs2_en;
      logic [4:0]  rs2_idx;
      logic        wb_en;
      logic [4:0]  wb_idx;
      logic [31:0] wb_wdata;
      logic        iv;
      logic        il;
      logic        ird_en;
      logic [4:0]  ird;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic        e_stall;
   } vec_t;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        stall;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_regs [32];
   logic        m_busy [32];
   vec_t        tbl [23];

   function automatic vec_t mk(logic r1e, logic [4:0] r1, logic r2e, logic [4:0] r2,
                               logic we, logic [4:0] wi, logic [31:0] wd,
                               logic iv, logic il, logic ire, logic [4:0] ird,
                               logic [31:0] e1, logic [31:0] e2, logic es);
      vec_t v;
      v.rs1_en = r1e;  v.rs1_idx = r1;  v.rs2_en = r2e;  v.rs2_idx = r2;
      v.wb_en = we;    v.wb_idx = wi;   v.wb_wdata = wd;
      v.iv = iv;       v.il = il;       v.ird_en = ire;  v.ird = ird;
      v.e_rs1 = e1;    v.e_rs2 = e2;    v.e_stall = es;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic logic [31:0] model_read(logic en, logic [4:0] idx, vec_t v);
      if (!en || idx == 5'd0) return '0;
      if (v.wb_en && v.wb_idx == idx) return v.wb_wdata;
      return m_regs[idx];
   endfunction

   function automatic logic model_stall(vec_t v);
      logic s1, s2;
      s1 = v.rs1_en && m_busy[v.rs1_idx] && !(v.wb_en && v.wb_idx == v.rs1_idx);
      s2 = v.rs2_en && m_busy[v.rs2_idx] && !(v.wb_en && v.wb_idx == v.rs2_idx);
      return s1 || s2;
   endfunction

   task automatic drive(input vec_t v);
      rf.rs1_en_i       = v.rs1_en;
      rf.rs1_idx_i      = v.rs1_idx;
      rf.rs2_en_i       = v.rs2_en;
      rf.rs2_idx_i      = v.rs2_idx;
      rf.wb_en_i        = v.wb_en;
      rf.wb_idx_i       = v.wb_idx;
      rf.wb_wdata_i     = v.wb_wdata;
      rf.issue_valid_i  = v.iv;
      rf.issue_load_i   = v.il;
      rf.issue_rd_en_i  = v.ird_en;
      rf.issue_rd_idx_i = v.ird;
   endtask

   // One cycle: drive, queue the expectation, compare on the falling edge, advance the model.
   task automatic apply(input vec_t v, input string name);
      exp_t e;
      drive(v);
      exp_q.push_back('{rs1: v.e_rs1, rs2: v.e_rs2, stall: v.e_stall});
      @(negedge clk);
      e = exp_q.pop_front();
      check({name, ".rs1"},   rf.rs1_rdata_o, e.rs1);
      check({name, ".rs2"},   rf.rs2_rdata_o, e.rs2);
      check({name, ".stall"}, {31'd0, rf.load_use_stall_o}, {31'd0, e.stall});
      @(posedge clk);
      if (v.wb_en && v.wb_idx != 5'd0) begin
         m_regs[v.wb_idx] = v.wb_wdata;
         m_busy[v.wb_idx] = 1'b0;
      end
      if (v.iv && v.il && v.ird_en && v.ird != 5'd0) m_busy[v.ird] = 1'b1;
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         assert (!(rf.load_use_stall_o && rf.issue_valid_i))
            else $error("FAIL issue_during_stall: issue_valid=1 while stall=1");
      end
   end

   initial begin
      vec_t v;
      tbl[0]  = mk(1, 5,  0, 0,  1, 5,  32'hDEADBEEF, 0, 0, 0, 0,  32'hDEADBEEF, 0, 0);
      tbl[1]  = mk(1, 5,  1, 0,  0, 0,  0,            0, 0, 0, 0,  32'hDEADBEEF, 0, 0);
      tbl[2]  = mk(1, 0,  1, 5,  1, 0,  32'h1234,     0, 0, 0, 0,  0, 32'hDEADBEEF, 0);
      tbl[3]  = mk(1, 0,  0, 5,  0, 0,  0,            0, 0, 0, 0,  0, 0, 0);
      tbl[4]  = mk(1, 5,  1, 7,  1, 7,  32'hA5A5A5A5, 0, 0, 0, 0,
                   32'hDEADBEEF, 32'hA5A5A5A5, 0);
      tbl[5]  = mk(1, 7,  1, 7,  0, 0,  0,            0, 0, 0, 0,
                   32'hA5A5A5A5, 32'hA5A5A5A5, 0);
      tbl[6]  = mk(1, 3,  0, 0,  0, 0,  0,            1, 1, 1, 3,  0, 0, 0);
      tbl[7]  = mk(1, 3,  0, 0,  0, 0,  0,            0, 0, 0, 0,  0, 0, 1);
      tbl[8]  = mk(1, 3,  0, 0,  0, 0,  0,            0, 0, 0, 0,  0, 0, 1);
      tbl[9]  = mk(1, 3,  0, 0,  1, 3,  32'h42,       0, 0, 0, 0,  32'h42, 0, 0);
      tbl[10] = mk(1, 3,  0, 0,  0, 0,  0,            0, 0, 0, 0,  32'h42, 0, 0);
      tbl[11] = mk(1, 6,  0, 0,  0, 0,  0,            1, 0, 1, 6,  0, 0, 0);
      tbl[12] = mk(0, 0,  1, 6,  0, 0,  0,            0, 0, 0, 0,  0, 0, 0);
      tbl[13] = mk(1, 9,  0, 0,  1, 9,  32'h99,       1, 1, 1, 9,  32'h99, 0, 0);
      tbl[14] = mk(1, 9,  0, 0,  0, 0,  0,            0, 0, 0, 0,  32'h99, 0, 1);
      tbl[15] = mk(1, 9,  1, 9,  0, 0,  0,            0, 0, 0, 0,  32'h99, 32'h99, 1);
      tbl[16] = mk(1, 9,  1, 9,  1, 9,  32'h77,       0, 0, 0, 0,  32'h77, 32'h77, 0);
      tbl[17] = mk(1, 1,  0, 0,  0, 0,  0,            1, 1, 1, 0,  0, 0, 0);
      tbl[18] = mk(1, 0,  1, 0,  0, 0,  0,            1, 1, 0, 10, 0, 0, 0);
      tbl[19] = mk(1, 10, 0, 0,  0, 0,  0,            0, 1, 1, 11, 0, 0, 0);
      tbl[20] = mk(1, 10, 1, 11, 0, 0,  0,            1, 1, 1, 12, 0, 0, 0);
      tbl[21] = mk(0, 12, 1, 12, 0, 0,  0,            0, 0, 0, 0,  0, 0, 1);
      tbl[22] = mk(0, 12, 1, 12, 1, 12, 32'h5,        0, 0, 0, 0,  0, 32'h5, 0);

      model_reset();
      drive(mk(1, 1, 1, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.rs1",   rf.rs1_rdata_o, 32'd0);
      check("reset.rs2",   rf.rs2_rdata_o, 32'd0);
      check("reset.stall", {31'd0, rf.load_use_stall_o}, 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 1; i < 32; i++) begin
         apply(mk(1, 5'(i), 1, 5'(32 - i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "init_read");
      end

      for (int i = 0; i < 23; i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Reset while a load to x4 is pending: stall must drop without a clock edge.
      apply(mk(0, 0, 0, 0, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0), "x4_write");
      apply(mk(1, 4, 0, 0, 0, 0, 0, 1, 1, 1, 4, 32'h44, 0, 0), "x4_issue");
      drive(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      check("pre_reset.stall", {31'd0, rf.load_use_stall_o}, 32'd1);
      check("pre_reset.rs1",   rf.rs1_rdata_o, 32'h44);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset.stall", {31'd0, rf.load_use_stall_o}, 32'd0);
      check("async_reset.rs1",   rf.rs1_rdata_o, 32'd0);
      model_reset();
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply(mk(1, 4, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset");

      for (int n = 0; n < 300; n++) begin
         v.rs1_en   = 1'($urandom_range(0, 3) != 0);
         v.rs1_idx  = 5'($urandom_range(0, 7));
         v.rs2_en   = 1'($urandom_range(0, 3) != 0);
         v.rs2_idx  = 5'($urandom_range(0, 7));
         v.wb_en    = 1'($urandom_range(0, 1));
         v.wb_idx   = 5'($urandom_range(0, 7));
         v.wb_wdata = $urandom;
         v.iv       = 1'($urandom_range(0, 1));
         v.il       = 1'($urandom_range(0, 2) != 0);
         v.ird_en   = 1'($urandom_range(0, 3) != 0);
         v.ird      = 5'($urandom_range(0, 7));
         v.e_stall  = model_stall(v);
         if (v.e_stall) v.iv = 1'b0;
         v.e_rs1    = model_read(v.rs1_en, v.rs1_idx, v);
         v.e_rs2    = model_read(v.rs2_en, v.rs2_idx, v);
         apply(v, "rand");
      end

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
